// File: rtl/sram_axi_bridge_np_if.sv
// sram_axi_bridge_np_if: AXI3 bus between the SRAM bridge (master) and the top-level pins (slave)
interface sram_axi_bridge_np_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge_np.sv
// sram_axi_bridge_np: NUM_PORTS SRAM-like ports onto one AXI3 master with round-robin grant and read return by ID.
// Optional SRAM_AXI_RAW_CHECK_EN: reads stall only when they hit the word of the in-flight write, not on any write.
module sram_axi_bridge_np #(
    parameter int NUM_PORTS = 2,
    parameter int ID_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   sram_req,
    input  logic [NUM_PORTS-1:0]   sram_wr,
    input  logic [2*NUM_PORTS-1:0] sram_size,
    input  logic [32*NUM_PORTS-1:0] sram_addr,
    input  logic [32*NUM_PORTS-1:0] sram_wdata,
    input  logic [4*NUM_PORTS-1:0] sram_wstrb,
    output logic [NUM_PORTS-1:0]   sram_addr_ok,
    output logic [NUM_PORTS-1:0]   sram_data_ok,
    output logic [32*NUM_PORTS-1:0] sram_rdata,
    sram_axi_bridge_np_if.master   axi
);
    localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0] busy, rd_ok, wr_ok;
    logic [31:0] addr [NUM_PORTS];
    logic [31:0] wdata [NUM_PORTS];
    logic [3:0]  wstrb [NUM_PORTS];
    logic [1:0]  size [NUM_PORTS];
    logic        wr_inflight;
    logic [29:0] wr_addr;
    logic [PW-1:0] ptr, gnt_idx, lo_idx, hi_idx;
    logic        lo_f, hi_f, grant, ar_free, aw_free, unused;

    assign ar_free = !axi.arvalid || axi.arready;
    assign aw_free = !wr_inflight && !axi.awvalid && !axi.wvalid;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        logic hazard, rhit, bhit;
        assign addr[g]  = sram_addr[32*g +: 32];
        assign wdata[g] = sram_wdata[32*g +: 32];
        assign wstrb[g] = sram_wstrb[4*g +: 4];
        assign size[g]  = sram_size[2*g +: 2];
`ifdef SRAM_AXI_RAW_CHECK_EN
        assign hazard = wr_inflight && !axi.bvalid && addr[g][31:2] == wr_addr;
`else
        assign hazard = wr_inflight && !axi.bvalid;
`endif
        assign rd_ok[g] = sram_req[g] && !sram_wr[g] && !busy[g] && ar_free && !hazard;
        assign wr_ok[g] = sram_req[g] && sram_wr[g] && !busy[g] && aw_free;
        assign rhit = axi.rvalid && axi.rid == ID_W'(g);
        assign bhit = axi.bvalid && axi.bid == ID_W'(g);
        assign sram_data_ok[g] = rhit || bhit;
        assign sram_rdata[32*g +: 32] = rhit ? axi.rdata : '0;
    end

    // Round-robin pick: lowest eligible index at or above ptr, else wrap to the lowest eligible index.
    always_comb begin
        lo_f = 1'b0;
        hi_f = 1'b0;
        lo_idx = '0;
        hi_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rd_ok[i] || wr_ok[i]) begin
                lo_f = 1'b1;
                lo_idx = PW'(i);
                if (PW'(i) >= ptr) begin
                    hi_f = 1'b1;
                    hi_idx = PW'(i);
                end
            end
        end
    end

    assign gnt_idx = hi_f ? hi_idx : lo_idx;
    assign grant = lo_f && !reset;
    assign sram_addr_ok = grant ? NUM_PORTS'(1) << gnt_idx : '0;

    assign axi.arlen   = '0;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = '0;
    assign axi.arcache = '0;
    assign axi.arprot  = '0;
    assign axi.awlen   = '0;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = '0;
    assign axi.awcache = '0;
    assign axi.awprot  = '0;
    assign axi.wlast   = 1'b1;
    assign axi.rready  = 1'b1;
    assign axi.bready  = 1'b1;
    assign unused = ^{axi.rresp, axi.bresp, axi.rlast};

    // Channel holding registers, per-port busy flags, write-in-flight tracking and the arbitration pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
            wr_inflight <= 1'b0;
            ptr <= '0;
            axi.arvalid <= 1'b0;
            axi.awvalid <= 1'b0;
            axi.wvalid <= 1'b0;
        end else begin
            busy <= (busy & ~sram_data_ok) | sram_addr_ok;
            if (axi.arready) axi.arvalid <= 1'b0;
            if (axi.awready) axi.awvalid <= 1'b0;
            if (axi.wready) axi.wvalid <= 1'b0;
            if (axi.bvalid) wr_inflight <= 1'b0;
            if (grant) begin
                ptr <= gnt_idx == PW'(NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
                if (sram_wr[gnt_idx]) begin
                    axi.awvalid <= 1'b1;
                    axi.wvalid <= 1'b1;
                    wr_inflight <= 1'b1;
                    wr_addr <= addr[gnt_idx][31:2];
                    axi.awid <= ID_W'(gnt_idx);
                    axi.wid <= ID_W'(gnt_idx);
                    axi.awaddr <= addr[gnt_idx];
                    axi.awsize <= {1'b0, size[gnt_idx]};
                    axi.wdata <= wdata[gnt_idx];
                    axi.wstrb <= wstrb[gnt_idx];
                end else begin
                    axi.arvalid <= 1'b1;
                    axi.arid <= ID_W'(gnt_idx);
                    axi.araddr <= addr[gnt_idx];
                    axi.arsize <= {1'b0, size[gnt_idx]};
                end
            end
        end
    end
endmodule
